// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file: NRD registered read ports, two write ports (W0 data/link, W1 writeback).
// PC index reads live pc_plus8; same-edge writes are bypassed to the read ports.
module arm_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int NRD      = 3,
  parameter int PC_REG   = 15,
  parameter int LR_REG   = 14,
  parameter int LINK_ADJ = 4,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic [1:0]            wmode0,
  input  logic [AW-1:0]         wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [DATA_W-1:0]     pc_plus8,
  output logic                  wr_drop
);

  localparam logic [AW-1:0]     PC_A  = AW'(PC_REG);
  localparam logic [AW-1:0]     LR_A  = AW'(LR_REG);
  localparam logic [AW:0]       NR_W  = (AW+1)'(NREGS);
  localparam logic [DATA_W-1:0] ADJ   = DATA_W'(LINK_ADJ);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd_next [NRD];

  logic              w0_req, w0_link, w0_commit, w1_commit, drop_next;
  logic [AW-1:0]     w0_addr;
  logic [DATA_W-1:0] w0_data;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NR_W);
  endfunction

  always_comb begin
    w0_req    = wmode0[1];
    w0_link   = (wmode0 == 2'b10);
    w0_addr   = w0_link ? LR_A : wa0;
    w0_data   = w0_link ? (pc_plus8 - ADJ) : wd0;
    w0_commit = w0_req && in_range(w0_addr) && (w0_addr != PC_A);
    // W1 loses any collision with a requested W0, even if W0 itself is discarded
    w1_commit = we1 && in_range(wa1) && (wa1 != PC_A) && !(w0_req && (wa1 == w0_addr));
    drop_next = (w0_req && !w0_commit) || (we1 && !w1_commit);
  end

  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_next[k] = '0;
      if (ra[k*AW +: AW] == PC_A)
        rd_next[k] = pc_plus8;
      else if (!in_range(ra[k*AW +: AW]))
        rd_next[k] = '0;
      else if (w0_commit && (w0_addr == ra[k*AW +: AW]))
        rd_next[k] = w0_data;
      else if (w1_commit && (wa1 == ra[k*AW +: AW]))
        rd_next[k] = wd1;
      else
        rd_next[k] = regs[ra[k*AW +: AW]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (w0_commit) regs[w0_addr] <= w0_data;
      if (w1_commit) regs[wa1]     <= wd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd      <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= drop_next;
      for (int unsigned k = 0; k < NRD; k++)
        if (rd_en[k]) rd[k*DATA_W +: DATA_W] <= rd_next[k];
    end
  end

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Directed bench for arm_regfile_mp: default instance plus an NRD=4, DATA_W=16 instance.
module tb_arm_regfile_mp;

  logic clk, reset;
  int   n_cmp, n_bad;

  logic [2:0]  a_en;
  logic [11:0] a_ra;
  logic [95:0] a_rd;
  logic [1:0]  a_wmode0;
  logic [3:0]  a_wa0, a_wa1;
  logic [31:0] a_wd0, a_wd1, a_pc8;
  logic        a_we1, a_drop;

  logic [3:0]  b_en;
  logic [15:0] b_ra;
  logic [63:0] b_rd;
  logic [1:0]  b_wmode0;
  logic [3:0]  b_wa0, b_wa1;
  logic [15:0] b_wd0, b_wd1, b_pc8;
  logic        b_we1, b_drop;

  arm_regfile_mp u_a (
    .clk(clk), .reset(reset), .rd_en(a_en), .ra(a_ra), .rd(a_rd),
    .wmode0(a_wmode0), .wa0(a_wa0), .wd0(a_wd0), .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
    .pc_plus8(a_pc8), .wr_drop(a_drop)
  );

  arm_regfile_mp #(.DATA_W(16), .NRD(4)) u_b (
    .clk(clk), .reset(reset), .rd_en(b_en), .ra(b_ra), .rd(b_rd),
    .wmode0(b_wmode0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .pc_plus8(b_pc8), .wr_drop(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle;
    a_en = '0; a_ra = '0; a_wmode0 = 2'b00; a_wa0 = '0; a_wd0 = '0;
    a_we1 = 1'b0; a_wa1 = '0; a_wd1 = '0;
  endtask

  task automatic b_idle;
    b_en = '0; b_ra = '0; b_wmode0 = 2'b00; b_wa0 = '0; b_wd0 = '0;
    b_we1 = 1'b0; b_wa1 = '0; b_wd1 = '0;
  endtask

  task automatic test_reset;
    n_cmp++; if (a_rd !== 96'd0) begin n_bad++; $display("FAIL reset_rd_a: got %h want 0", a_rd); end
    n_cmp++; if (a_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop_a: got %b want 0", a_drop); end
    n_cmp++; if (b_rd !== 64'd0) begin n_bad++; $display("FAIL reset_rd_b: got %h want 0", b_rd); end
    reset = 1'b0;
    tick();
    a_wmode0 = 2'b11; a_wa0 = 4'd3; a_wd0 = 32'hDEAD; a_ra = {4'd0, 4'd0, 4'd3}; a_en = 3'b001;
    tick();
    n_cmp++; if (a_rd[31:0] !== 32'hDEAD) begin n_bad++; $display("FAIL r3_write: got %h want 0000dead", a_rd[31:0]); end
    a_idle(); a_ra = {4'd3, 4'd3, 4'd3}; a_en = 3'b111;
    tick();
    n_cmp++; if (a_rd !== {3{32'hDEAD}}) begin n_bad++; $display("FAIL r3_all_ports: got %h want %h", a_rd, {3{32'hDEAD}}); end
    a_idle();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (a_rd !== 96'd0) begin n_bad++; $display("FAIL async_reset_rd: got %h want 0", a_rd); end
    #1 reset = 1'b0;
    a_ra = {4'd0, 4'd0, 4'd3}; a_en = 3'b001;
    tick();
    n_cmp++; if (a_rd[31:0] !== 32'd0) begin n_bad++; $display("FAIL r3_after_reset: got %h want 0", a_rd[31:0]); end
    a_idle();
  endtask

  task automatic test_bypass;
    a_wmode0 = 2'b11; a_wa0 = 4'd5; a_wd0 = 32'h1234; a_ra = {4'd0, 4'd0, 4'd5}; a_en = 3'b001;
    tick();
    n_cmp++; if (a_rd[31:0] !== 32'h1234) begin n_bad++; $display("FAIL bypass_w0: got %h want 00001234", a_rd[31:0]); end
    n_cmp++; if (a_drop !== 1'b0) begin n_bad++; $display("FAIL bypass_drop: got %b want 0", a_drop); end
    a_idle(); a_we1 = 1'b1; a_wa1 = 4'd6; a_wd1 = 32'h777; a_ra = {4'd0, 4'd6, 4'd0}; a_en = 3'b010;
    tick();
    n_cmp++; if (a_rd[63:32] !== 32'h777) begin n_bad++; $display("FAIL bypass_w1: got %h want 00000777", a_rd[63:32]); end
    a_idle();
  endtask

  task automatic test_link;
    a_pc8 = 32'h108; a_wmode0 = 2'b10; a_wa0 = 4'd3; a_wd0 = 32'hFFFF;
    tick();
    a_idle(); a_pc8 = 32'h200; a_ra = {4'd3, 4'd15, 4'd14}; a_en = 3'b111;
    tick();
    n_cmp++; if (a_rd[31:0] !== 32'h104) begin n_bad++; $display("FAIL link_r14: got %h want 00000104", a_rd[31:0]); end
    n_cmp++; if (a_rd[63:32] !== 32'h200) begin n_bad++; $display("FAIL pc_read: got %h want 00000200", a_rd[63:32]); end
    n_cmp++; if (a_rd[95:64] !== 32'd0) begin n_bad++; $display("FAIL link_wa0_ignored: got %h want 0", a_rd[95:64]); end
    a_idle(); a_pc8 = 32'd2; a_wmode0 = 2'b10; a_ra = {4'd14, 4'd0, 4'd0}; a_en = 3'b100;
    tick();
    n_cmp++; if (a_rd[95:64] !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL link_wrap: got %h want fffffffe", a_rd[95:64]); end
    a_idle();
  endtask

  task automatic test_collision;
    a_wmode0 = 2'b11; a_wa0 = 4'd2; a_wd0 = 32'hA; a_we1 = 1'b1; a_wa1 = 4'd2; a_wd1 = 32'hB;
    tick();
    n_cmp++; if (a_drop !== 1'b1) begin n_bad++; $display("FAIL collide_drop: got %b want 1", a_drop); end
    a_idle(); a_ra = {4'd0, 4'd0, 4'd2}; a_en = 3'b001;
    tick();
    n_cmp++; if (a_rd[31:0] !== 32'hA) begin n_bad++; $display("FAIL collide_w0_wins: got %h want 0000000a", a_rd[31:0]); end
    n_cmp++; if (a_drop !== 1'b0) begin n_bad++; $display("FAIL collide_drop_pulse: got %b want 0", a_drop); end
    a_wmode0 = 2'b11; a_wa0 = 4'd2; a_wd0 = 32'h11; a_we1 = 1'b1; a_wa1 = 4'd3; a_wd1 = 32'h22;
    a_ra = {4'd0, 4'd3, 4'd2}; a_en = 3'b011;
    tick();
    n_cmp++; if (a_rd[63:0] !== {32'h22, 32'h11}) begin n_bad++; $display("FAIL dual_bypass: got %h want 0000002200000011", a_rd[63:0]); end
    n_cmp++; if (a_drop !== 1'b0) begin n_bad++; $display("FAIL dual_drop: got %b want 0", a_drop); end
    a_idle(); a_ra = {4'd0, 4'd2, 4'd3}; a_en = 3'b011;
    tick();
    n_cmp++; if (a_rd[63:0] !== {32'h11, 32'h22}) begin n_bad++; $display("FAIL dual_stored: got %h want 0000001100000022", a_rd[63:0]); end
    a_idle();
  endtask

  task automatic test_pc_write;
    a_pc8 = 32'h300; a_we1 = 1'b1; a_wa1 = 4'd15; a_wd1 = 32'h55; a_ra = {4'd0, 4'd0, 4'd15}; a_en = 3'b001;
    tick();
    n_cmp++; if (a_drop !== 1'b1) begin n_bad++; $display("FAIL pc_w1_drop: got %b want 1", a_drop); end
    n_cmp++; if (a_rd[31:0] !== 32'h300) begin n_bad++; $display("FAIL pc_w1_read: got %h want 00000300", a_rd[31:0]); end
    a_idle(); a_pc8 = 32'h400; a_wmode0 = 2'b11; a_wa0 = 4'd15; a_wd0 = 32'h66; a_ra = {4'd0, 4'd0, 4'd15}; a_en = 3'b001;
    tick();
    n_cmp++; if (a_drop !== 1'b1) begin n_bad++; $display("FAIL pc_w0_drop: got %b want 1", a_drop); end
    n_cmp++; if (a_rd[31:0] !== 32'h400) begin n_bad++; $display("FAIL pc_w0_read: got %h want 00000400", a_rd[31:0]); end
    a_idle(); a_wmode0 = 2'b01; a_wa0 = 4'd4; a_wd0 = 32'h99; a_ra = {4'd0, 4'd0, 4'd4}; a_en = 3'b001;
    tick();
    n_cmp++; if (a_drop !== 1'b0) begin n_bad++; $display("FAIL reserved_drop: got %b want 0", a_drop); end
    n_cmp++; if (a_rd[31:0] !== 32'd0) begin n_bad++; $display("FAIL reserved_noop: got %h want 0", a_rd[31:0]); end
    a_idle();
  endtask

  task automatic test_hold;
    a_we1 = 1'b1; a_wa1 = 4'd7; a_wd1 = 32'h70; a_ra = {4'd0, 4'd7, 4'd0}; a_en = 3'b010;
    tick();
    n_cmp++; if (a_rd[63:32] !== 32'h70) begin n_bad++; $display("FAIL hold_setup: got %h want 00000070", a_rd[63:32]); end
    a_idle(); a_wmode0 = 2'b11; a_wa0 = 4'd7; a_wd0 = 32'h71; a_ra = {4'd0, 4'd7, 4'd7}; a_en = 3'b001;
    tick();
    n_cmp++; if (a_rd[63:32] !== 32'h70) begin n_bad++; $display("FAIL hold_port1: got %h want 00000070", a_rd[63:32]); end
    n_cmp++; if (a_rd[31:0] !== 32'h71) begin n_bad++; $display("FAIL hold_port0_new: got %h want 00000071", a_rd[31:0]); end
    a_idle();
  endtask

  task automatic test_wide_regression;
    b_wmode0 = 2'b11; b_wa0 = 4'd5; b_wd0 = 16'h1234; b_ra = {4'd5, 4'd0, 4'd0, 4'd0}; b_en = 4'b1000;
    tick();
    n_cmp++; if (b_rd[63:48] !== 16'h1234) begin n_bad++; $display("FAIL b_bypass: got %h want 1234", b_rd[63:48]); end
    b_idle(); b_pc8 = 16'h108; b_wmode0 = 2'b10;
    tick();
    b_idle(); b_pc8 = 16'h200; b_ra = {4'd0, 4'd0, 4'd15, 4'd14}; b_en = 4'b0011;
    tick();
    n_cmp++; if (b_rd[31:0] !== {16'h200, 16'h104}) begin n_bad++; $display("FAIL b_link_pc: got %h want 02000104", b_rd[31:0]); end
    b_idle(); b_pc8 = 16'd2; b_wmode0 = 2'b10; b_ra = {4'd0, 4'd14, 4'd0, 4'd0}; b_en = 4'b0100;
    tick();
    n_cmp++; if (b_rd[47:32] !== 16'hFFFE) begin n_bad++; $display("FAIL b_link_wrap: got %h want fffe", b_rd[47:32]); end
    b_idle(); b_wmode0 = 2'b11; b_wa0 = 4'd2; b_wd0 = 16'hA; b_we1 = 1'b1; b_wa1 = 4'd2; b_wd1 = 16'hB;
    tick();
    n_cmp++; if (b_drop !== 1'b1) begin n_bad++; $display("FAIL b_collide_drop: got %b want 1", b_drop); end
    b_idle(); b_ra = {4'd2, 4'd0, 4'd0, 4'd0}; b_en = 4'b1000;
    tick();
    n_cmp++; if (b_rd[63:48] !== 16'hA) begin n_bad++; $display("FAIL b_collide_w0_wins: got %h want 000a", b_rd[63:48]); end
    n_cmp++; if (b_drop !== 1'b0) begin n_bad++; $display("FAIL b_collide_pulse: got %b want 0", b_drop); end
    b_idle();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    a_idle(); b_idle();
    a_pc8 = 32'h8; b_pc8 = 16'h8;
    repeat (2) tick();
    test_reset();
    test_bypass();
    test_link();
    test_collision();
    test_pc_write();
    test_hold();
    test_wide_regression();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
